// File: rtl/cipher_pkg.sv
// Shared constants for the Vernam cipher datapath: PicoBlaze port map,
// status byte layout and the serialiser state encoding.
package cipher_pkg;

   localparam logic [7:0] DATA_ADDR   = 8'h04;
   localparam logic [7:0] STATUS_ADDR = 8'h08;

   localparam int unsigned ST_FULL    = 7;
   localparam int unsigned ST_EMPTY   = 6;
   localparam int unsigned ST_OVF     = 5;
   localparam int unsigned ST_CNT_MSB = 4;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// DEPTH x 8 synchronous FIFO; a push while full is accepted when a pop
// happens in the same cycle.
module sync_fifo #(
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_push,
   input  logic [7:0]    i_data,
   input  logic          i_pop,
   output logic [7:0]    o_data,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_count
);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/cipher_tx.sv
// Ciphertext output stage: PicoBlaze port decode, FIFO, status register and
// 8N1 serialiser. All outputs are registered.
module cipher_tx
   import cipher_pkg::*;
#(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic       write_strobe,
   input  logic       read_strobe,
   output logic [7:0] status,
   output logic       tx,
   output logic       busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned BW = $clog2(CLKS_PER_BIT);

   tx_state_t    r_state, w_state_nxt;
   logic [BW-1:0] r_baud, w_baud_nxt;
   logic [2:0]   r_bit, w_bit_nxt;
   logic [7:0]   r_shift, w_shift_nxt;
   logic         r_tx, w_tx_nxt;
   logic         r_busy;
   logic         r_overflow;
   logic [7:0]   r_status, w_status_d;

   logic         w_push_req, w_clr_req, w_ovf_set, w_pop, w_baud_last;
   logic         w_full, w_empty;
   logic [7:0]   w_rd_data;
   logic [AW:0]  w_count;

   assign w_push_req  = write_strobe && (port_id == DATA_ADDR);
   assign w_clr_req   = read_strobe && (port_id == STATUS_ADDR);
   assign w_ovf_set   = w_push_req && w_full && !w_pop;
   assign w_baud_last = (r_baud == BW'(CLKS_PER_BIT - 1));

   sync_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk   (clk),
      .i_reset (reset),
      .i_push  (w_push_req),
      .i_data  (out_port),
      .i_pop   (w_pop),
      .o_data  (w_rd_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // tx is registered from the current state, so the line lags the FSM by one cycle
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = w_baud_last ? '0 : r_baud + BW'(1);
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_pop       = 1'b0;
      w_tx_nxt    = 1'b1;
      unique case (r_state)
         IDLE: begin
            w_baud_nxt = '0;
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_rd_data;
               w_state_nxt = START;
            end
         end
         START: begin
            w_tx_nxt = 1'b0;
            if (w_baud_last) begin
               w_bit_nxt   = '0;
               w_state_nxt = DATA;
            end
         end
         DATA: begin
            w_tx_nxt = r_shift[0];
            if (w_baud_last) begin
               w_shift_nxt = {1'b0, r_shift[7:1]};
               w_bit_nxt   = r_bit + 3'd1;
               if (r_bit == 3'd7) w_state_nxt = STOP;
            end
         end
         STOP: begin
            if (w_baud_last) begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_shift_nxt = w_rd_data;
                  w_state_nxt = START;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_status_d                 = '0;
      w_status_d[ST_FULL]        = w_full;
      w_status_d[ST_EMPTY]       = w_empty;
      w_status_d[ST_OVF]         = r_overflow;
      w_status_d[ST_CNT_MSB:0]   = 5'(w_count);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_baud     <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_overflow <= 1'b0;
         r_status   <= 8'h40;
      end else begin
         r_state  <= w_state_nxt;
         r_baud   <= w_baud_nxt;
         r_bit    <= w_bit_nxt;
         r_shift  <= w_shift_nxt;
         r_tx     <= w_tx_nxt;
         r_busy   <= !((r_state == IDLE) && w_empty);
         r_status <= w_status_d;
         if (w_ovf_set)      r_overflow <= 1'b1;
         else if (w_clr_req) r_overflow <= 1'b0;
      end
   end

   assign tx     = r_tx;
   assign busy   = r_busy;
   assign status = r_status;

endmodule

// File: doc/cipher_tx.md
# cipher_tx

Downstream stage of the Vernam cipher datapath: captures ciphertext bytes written by the cipher PicoBlaze (`out_port` qualified by `write_strobe` and `port_id`) into a small FIFO and serialises them onto a single wire as 8N1 asynchronous frames. A registered status byte lets the PicoBlaze poll fill level and overflow before writing, so the processor never stalls on the serial rate.

## Interface
- `DATA_ADDR`, 8'h04: `port_id` value that pushes `out_port` into the FIFO.
- `STATUS_ADDR`, 8'h08: `port_id` value whose read clears the overflow flag.
- `DEPTH`, 16: FIFO entries; power of two, 2..16.
- `CLKS_PER_BIT`, 16: clocks per serial bit; minimum 2.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `port_id`  in  8  PicoBlaze port address.
- `out_port`  in  8  PicoBlaze write data (ciphertext byte).
- `write_strobe`  in  1  PicoBlaze write qualifier.
- `read_strobe`  in  1  PicoBlaze read qualifier.
- `status`  out  8  registered `{full, empty, overflow, count[4:0]}`; routed to the in_port mux.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.

## Operation
- Push: `write_strobe && port_id == DATA_ADDR` and FIFO not full → `out_port` enqueued.
- Push while full and no pop in the same cycle → byte dropped, `overflow` set (sticky).
- Push while full with a pop in the same cycle → push accepted, count unchanged, no overflow.
- `overflow` cleared by `read_strobe && port_id == STATUS_ADDR`. A set and a clear in the same cycle → set wins.
- Transmitter FSM:
  - IDLE: `tx` = 1. If FIFO not empty, pop into the shift register and go to START.
  - START: `tx` = 0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each, then STOP.
  - STOP: `tx` = 1 for CLKS_PER_BIT cycles. On the last cycle, if FIFO not empty, pop and go to START (back-to-back frames); else IDLE.
- Bit counter: 3 bits. Baud counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1 and wraps.
- FIFO pointers: $clog2(DEPTH) bits, natural wrap. `count` is 0..DEPTH, zero-extended to 5 bits.
- Reset values: `tx` = 1, `busy` = 0, `status` = 8'h40 (empty = 1), FIFO emptied, FSM in IDLE, `overflow` = 0.
- Reset mid-frame: frame aborted, `tx` high on the cycle after reset is sampled, queued data discarded.

## Timing
- `tx` and `status` come straight from flops.
- Push sampled at edge N → `count`/`empty` reflect it in `status` after edge N+1 (status registers the post-push state).
- FIFO empty and FSM in IDLE, push at edge N → pop at edge N+1 → `tx` falls after edge N+2.
- One frame = 10 × CLKS_PER_BIT cycles. Back-to-back frames have no idle gap.
- `busy` deasserts on the first IDLE cycle with the FIFO empty.
- No combinational path from `port_id`/`write_strobe` to any output.

## Structure
- Shared package `cipher_pkg`: the port-address constants (`DATA_ADDR`, `STATUS_ADDR`), the status bit positions, and the `tx_state_t` enum {IDLE, START, DATA, STOP}. The same address constants drive the in_port mux select decode.
- One sub-module, `sync_fifo`: `DEPTH` × 8, push/pop/full/empty/count, simultaneous push+pop legal when full.
- `cipher_tx` holds the port decode, overflow flag, status register and serialiser FSM.

## Test plan
All scenarios use CLKS_PER_BIT = 4, DEPTH = 4.
- Reset released, no writes → `tx` = 1, `status` = 8'h40, `busy` = 0 for 100 cycles.
- Write 8'hA5 to DATA_ADDR → `tx` falls 2 cycles later. Sampled mid-bit sequence: 0,1,0,1,0,0,1,0,1,1. `busy` drops 40 cycles after the start bit.
- Write 8'h01, 8'h02, 8'h03 on consecutive strobes → three contiguous 40-cycle frames in order, no idle gap between them.
- Six writes while the first frame is active → count saturates at 4, `status[5]` = 1. Reading STATUS_ADDR clears it; the four queued bytes are transmitted in order.
- Write to port 8'h05, and `read_strobe` on DATA_ADDR → FIFO untouched, `tx` stays high.
- Assert `reset` during DATA bit 3 of a frame → `tx` = 1 the next cycle, `status` = 8'h40, and no further frames once `reset` is released.
